switch_mcu_decoder_pipe: RTL and testbench

- Buffered, pipelined RV32I instruction decoder for the switch MCU core. It accepts {pc, instruction} pairs from fetch over a valid/ready handshake and queues them in a DEPTH-entry FIFO.
- Each instruction is decoded into a compact op code, register indices and a fully sign-extended immediate, with an illegal-instruction flag.
- Results are held in an output register for the execute stage under a second valid/ready handshake.
- Includes a synchronous flush for branch redirects and parametrised enables for the CSR and FENCE groups.

---
 rtl/switch_mcu_decoder_pipe.sv | 240 ++++++++++++++++++++++++
 tb/tb_switch_mcu_decoder_pipe.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/switch_mcu_decoder_pipe.sv
// RV32I decoder: DEPTH-entry {pc,inst} FIFO feeding one registered decode stage, 2-edge latency.
// Backpressure: out_inst_ready depends only on FIFO occupancy; the output register holds while !in_dec_ready.
module switch_mcu_decoder_pipe #(
    parameter int DEPTH    = 2,
    parameter int PC_WIDTH = 32,
    parameter bit EN_CSR   = 1'b1,
    parameter bit EN_FENCE = 1'b1
) (
    input  logic                       in_clk,
    input  logic                       in_rst,
    input  logic                       in_inst_valid,
    input  logic [31:0]                in_inst,
    input  logic [PC_WIDTH-1:0]        in_pc,
    output logic                       out_inst_ready,
    input  logic                       in_flush,
    output logic                       out_dec_valid,
    input  logic                       in_dec_ready,
    output logic [5:0]                 out_op,
    output logic                       out_illegal,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [4:0]                 out_rd,
    output logic [31:0]                out_imm,
    output logic [PC_WIDTH-1:0]        out_pc,
    output logic [$clog2(DEPTH):0]     out_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [31:0]         inst;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wptr_q, rptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               valid_q;
    logic [5:0]         op_q;
    logic               illegal_q;
    logic [4:0]         rs1_q, rs2_q, rd_q;
    logic [31:0]        imm_q;
    logic [PC_WIDTH-1:0] pc_q;

    logic push, pop;
    entry_t head;
    logic [31:0] inst;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [5:0]  dec_op;
    logic [31:0] dec_imm;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh, imm_csr;

    assign out_inst_ready = (count_q != CNT_W'(DEPTH));
    // Flush wins over both handshakes, so neither side moves on a flush edge.
    assign push = in_inst_valid && out_inst_ready && !in_flush;
    assign pop  = (count_q != '0) && (!valid_q || in_dec_ready) && !in_flush;

    assign head = mem_q[rptr_q];
    assign inst = head.inst;
    assign opc  = inst[6:0];
    assign f3   = inst[14:12];
    assign f7   = inst[31:25];

    assign imm_i   = {{20{inst[31]}}, inst[31:20]};
    assign imm_s   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u   = {inst[31:12], 12'b0};
    assign imm_j   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign imm_sh  = {27'b0, inst[24:20]};
    assign imm_csr = {20'b0, inst[31:20]};

    always_comb begin
        dec_op  = 6'd0;
        dec_imm = 32'd0;
        case (opc)
            7'b0110111: begin dec_op = 6'd1; dec_imm = imm_u; end
            7'b0010111: begin dec_op = 6'd2; dec_imm = imm_u; end
            7'b1101111: begin dec_op = 6'd3; dec_imm = imm_j; end
            7'b1100111: if (f3 == 3'b000) begin dec_op = 6'd4; dec_imm = imm_i; end
            7'b1100011: begin
                case (f3)
                    3'b000:  dec_op = 6'd5;
                    3'b001:  dec_op = 6'd6;
                    3'b100:  dec_op = 6'd7;
                    3'b101:  dec_op = 6'd8;
                    3'b110:  dec_op = 6'd9;
                    3'b111:  dec_op = 6'd10;
                    default: dec_op = 6'd0;
                endcase
                dec_imm = imm_b;
            end
            7'b0000011: begin
                case (f3)
                    3'b000:  dec_op = 6'd11;
                    3'b001:  dec_op = 6'd12;
                    3'b010:  dec_op = 6'd13;
                    3'b100:  dec_op = 6'd14;
                    3'b101:  dec_op = 6'd15;
                    default: dec_op = 6'd0;
                endcase
                dec_imm = imm_i;
            end
            7'b0100011: begin
                case (f3)
                    3'b000:  dec_op = 6'd16;
                    3'b001:  dec_op = 6'd17;
                    3'b010:  dec_op = 6'd18;
                    default: dec_op = 6'd0;
                endcase
                dec_imm = imm_s;
            end
            7'b0010011: begin
                dec_imm = imm_i;
                case (f3)
                    3'b000: dec_op = 6'd19;
                    3'b010: dec_op = 6'd20;
                    3'b011: dec_op = 6'd21;
                    3'b100: dec_op = 6'd22;
                    3'b110: dec_op = 6'd23;
                    3'b111: dec_op = 6'd24;
                    3'b001: begin
                        dec_imm = imm_sh;
                        if (f7 == 7'b0000000) dec_op = 6'd25;
                    end
                    default: begin
                        dec_imm = imm_sh;
                        if (f7 == 7'b0000000)      dec_op = 6'd26;
                        else if (f7 == 7'b0100000) dec_op = 6'd27;
                    end
                endcase
            end
            7'b0110011: begin
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000:  dec_op = 6'd28;
                        3'b001:  dec_op = 6'd30;
                        3'b010:  dec_op = 6'd31;
                        3'b011:  dec_op = 6'd32;
                        3'b100:  dec_op = 6'd33;
                        3'b101:  dec_op = 6'd34;
                        3'b110:  dec_op = 6'd36;
                        default: dec_op = 6'd37;
                    endcase
                end else if (f7 == 7'b0100000) begin
                    if (f3 == 3'b000)      dec_op = 6'd29;
                    else if (f3 == 3'b101) dec_op = 6'd35;
                end
            end
            7'b0001111: begin
                if (EN_FENCE) begin
                    if (inst == 32'h0000100F) begin
                        dec_op = 6'd39;
                    end else if (f3 == 3'b000) begin
                        dec_op  = 6'd38;
                        dec_imm = imm_i;
                    end
                end
            end
            7'b1110011: begin
                if (EN_CSR) begin
                    if (inst == 32'h00000073)      dec_op = 6'd40;
                    else if (inst == 32'h00100073) dec_op = 6'd41;
                    else begin
                        case (f3)
                            3'b001:  dec_op = 6'd42;
                            3'b010:  dec_op = 6'd43;
                            3'b011:  dec_op = 6'd44;
                            3'b101:  dec_op = 6'd45;
                            3'b110:  dec_op = 6'd46;
                            3'b111:  dec_op = 6'd47;
                            default: dec_op = 6'd0;
                        endcase
                        if (dec_op != 6'd0) dec_imm = imm_csr;
                    end
                end
            end
            default: dec_op = 6'd0;
        endcase
        if (dec_op == 6'd0) dec_imm = 32'd0;
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (!push && pop) count_d = count_q - CNT_W'(1);
    end

    // Storage carries no reset; occupancy is tracked by the pointers and count alone.
    always_ff @(posedge in_clk) begin
        if (push) mem_q[wptr_q] <= '{pc: in_pc, inst: in_inst};
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            op_q      <= '0;
            illegal_q <= 1'b0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            pc_q      <= '0;
        end else if (in_flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) wptr_q <= wptr_q + PTR_W'(1);
            if (pop) begin
                rptr_q    <= rptr_q + PTR_W'(1);
                valid_q   <= 1'b1;
                op_q      <= dec_op;
                illegal_q <= (dec_op == 6'd0);
                rs1_q     <= inst[19:15];
                rs2_q     <= inst[24:20];
                rd_q      <= inst[11:7];
                imm_q     <= dec_imm;
                pc_q      <= head.pc;
            end else if (in_dec_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out_dec_valid = valid_q;
    assign out_op        = op_q;
    assign out_illegal   = illegal_q;
    assign out_rs1       = rs1_q;
    assign out_rs2       = rs2_q;
    assign out_rd        = rd_q;
    assign out_imm       = imm_q;
    assign out_pc        = pc_q;
    assign out_count     = count_q;
endmodule

// File: tb/tb_switch_mcu_decoder_pipe.sv
// Bench for switch_mcu_decoder_pipe: directed vectors into a scoreboard, with a second
// instance built with CSR and FENCE groups disabled sharing the same stimulus.
module tb_switch_mcu_decoder_pipe;
    localparam int DEPTH = 2;

    logic        in_clk = 1'b0;
    logic        in_rst = 1'b0;
    logic        in_inst_valid = 1'b0;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic        in_flush = 1'b0;
    logic        in_dec_ready = 1'b1;

    logic        out_inst_ready, out_dec_valid, out_illegal;
    logic [5:0]  out_op;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [31:0] out_imm, out_pc;
    logic [1:0]  out_count;

    logic        b_inst_ready, b_dec_valid, b_illegal;
    logic [5:0]  b_op;
    logic [4:0]  b_rs1, b_rs2, b_rd;
    logic [31:0] b_imm, b_pc;
    logic [1:0]  b_count;

    switch_mcu_decoder_pipe #(.DEPTH(DEPTH), .PC_WIDTH(32), .EN_CSR(1'b1), .EN_FENCE(1'b1)) dut (
        .in_clk(in_clk), .in_rst(in_rst), .in_inst_valid(in_inst_valid), .in_inst(in_inst),
        .in_pc(in_pc), .out_inst_ready(out_inst_ready), .in_flush(in_flush),
        .out_dec_valid(out_dec_valid), .in_dec_ready(in_dec_ready), .out_op(out_op),
        .out_illegal(out_illegal), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_imm(out_imm), .out_pc(out_pc), .out_count(out_count));

    switch_mcu_decoder_pipe #(.DEPTH(DEPTH), .PC_WIDTH(32), .EN_CSR(1'b0), .EN_FENCE(1'b0)) dut_b (
        .in_clk(in_clk), .in_rst(in_rst), .in_inst_valid(in_inst_valid), .in_inst(in_inst),
        .in_pc(in_pc), .out_inst_ready(b_inst_ready), .in_flush(in_flush),
        .out_dec_valid(b_dec_valid), .in_dec_ready(in_dec_ready), .out_op(b_op),
        .out_illegal(b_illegal), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd),
        .out_imm(b_imm), .out_pc(b_pc), .out_count(b_count));

    always #5 in_clk = ~in_clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [5:0]  op;
        logic        ill;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic [5:0]  op_b;
        logic        ill_b;
        logic [31:0] imm_b;
    } vec_t;

    typedef struct packed {
        vec_t        v;
        logic [31:0] pc;
    } exp_t;

    vec_t vt [11];
    exp_t q [$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Monitor: pops on each accepted output, and while stalled checks the held value is the queue head.
    always @(negedge in_clk) begin
        exp_t e;
        if (in_rst && out_dec_valid) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_output actual_pc=%0h required=no_output", out_pc);
            end else begin
                e = in_dec_ready ? q.pop_front() : q[0];
                chk(in_dec_ready ? "dec_a" : "stall_hold_a",
                    128'({out_op, out_illegal, out_rs1, out_rs2, out_rd, out_imm, out_pc}),
                    128'({e.v.op, e.v.ill, e.v.rs1, e.v.rs2, e.v.rd, e.v.imm, e.pc}));
                chk(in_dec_ready ? "dec_b" : "stall_hold_b",
                    128'({b_dec_valid, b_op, b_illegal, b_rs1, b_rs2, b_rd, b_imm, b_pc}),
                    128'({1'b1, e.v.op_b, e.v.ill_b, e.v.rs1, e.v.rs2, e.v.rd, e.v.imm_b, e.pc}));
            end
        end
    end

    task automatic send(input int idx, input logic [31:0] pc);
        int n = 0;
        bit acc = 1'b0;
        in_inst_valid = 1'b1;
        in_inst = vt[idx].inst;
        in_pc = pc;
        while (!acc && n < 50) begin
            @(negedge in_clk);
            acc = out_inst_ready;
            @(posedge in_clk);
            #1;
            n++;
        end
        in_inst_valid = 1'b0;
        if (acc) q.push_back('{v: vt[idx], pc: pc});
        else begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=not_accepted required=accepted idx=%0d", idx);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge in_clk);
            #1;
            n++;
        end
        chk("drain_empty", 128'(q.size()), 128'(0));
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge in_clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        //           inst          op    ill   rs1   rs2   rd     imm            op_b  ill_b imm_b
        vt[0]  = '{32'h00500093, 6'd19, 1'b0, 5'd0, 5'd5, 5'd1,  32'h00000005, 6'd19, 1'b0, 32'h00000005};
        vt[1]  = '{32'hFE000EE3, 6'd5,  1'b0, 5'd0, 5'd0, 5'd29, 32'hFFFFFFFC, 6'd5,  1'b0, 32'hFFFFFFFC};
        vt[2]  = '{32'h800000EF, 6'd3,  1'b0, 5'd0, 5'd0, 5'd1,  32'hFFF00000, 6'd3,  1'b0, 32'hFFF00000};
        vt[3]  = '{32'h4030D113, 6'd27, 1'b0, 5'd1, 5'd3, 5'd2,  32'h00000003, 6'd27, 1'b0, 32'h00000003};
        vt[4]  = '{32'h123452B7, 6'd1,  1'b0, 5'd8, 5'd3, 5'd5,  32'h12345000, 6'd1,  1'b0, 32'h12345000};
        vt[5]  = '{32'hFE20AC23, 6'd18, 1'b0, 5'd1, 5'd2, 5'd24, 32'hFFFFFFF8, 6'd18, 1'b0, 32'hFFFFFFF8};
        vt[6]  = '{32'h30029073, 6'd42, 1'b0, 5'd5, 5'd0, 5'd0,  32'h00000300, 6'd0,  1'b1, 32'h00000000};
        vt[7]  = '{32'h40000033, 6'd29, 1'b0, 5'd0, 5'd0, 5'd0,  32'h00000000, 6'd29, 1'b0, 32'h00000000};
        vt[8]  = '{32'h80000033, 6'd0,  1'b1, 5'd0, 5'd0, 5'd0,  32'h00000000, 6'd0,  1'b1, 32'h00000000};
        vt[9]  = '{32'h00000073, 6'd40, 1'b0, 5'd0, 5'd0, 5'd0,  32'h00000000, 6'd0,  1'b1, 32'h00000000};
        vt[10] = '{32'h0000100F, 6'd39, 1'b0, 5'd0, 5'd0, 5'd0,  32'h00000000, 6'd0,  1'b1, 32'h00000000};

        // Reset state.
        cycles(3);
        chk("reset_outputs", 128'({out_dec_valid, out_op, out_illegal, out_rs1, out_rs2, out_rd, out_imm, out_pc}), 128'(0));
        chk("reset_count_ready", 128'({out_count, out_inst_ready, b_count, b_inst_ready}), 128'({2'd0, 1'b1, 2'd0, 1'b1}));
        in_rst = 1'b1;
        cycles(1);

        // First instruction and its two-edge latency.
        send(0, 32'h100);
        chk("latency_edge_e", 128'(out_dec_valid), 128'(0));
        cycles(1);
        chk("latency_edge_e1", 128'({out_dec_valid, out_op, out_imm, out_pc}), 128'({1'b1, 6'd19, 32'd5, 32'h100}));
        drain();

        // Back-to-back decode of every vector.
        for (int i = 1; i < 11; i++) send(i, 32'h1000 + 32'(4 * i));
        drain();

        // Fill while stalled, then release and check single-cycle throughput.
        in_dec_ready = 1'b0;
        send(7, 32'h2000);
        send(8, 32'h2004);
        send(9, 32'h2008);
        chk("full_count_ready", 128'({out_count, out_inst_ready}), 128'({2'd2, 1'b0}));
        cycles(2);
        in_dec_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge in_clk);
            chk("drain_throughput", 128'(out_dec_valid), 128'(1));
        end
        drain();

        // Flush with a full FIFO and a held result.
        in_dec_ready = 1'b0;
        send(1, 32'h3000);
        send(2, 32'h3004);
        send(3, 32'h3008);
        in_flush = 1'b1;
        in_inst_valid = 1'b1;
        in_inst = vt[4].inst;
        in_pc = 32'h300C;
        cycles(1);
        in_flush = 1'b0;
        in_inst_valid = 1'b0;
        q.delete();
        chk("flush_full", 128'({out_count, out_dec_valid}), 128'(0));
        in_dec_ready = 1'b1;
        cycles(4);
        chk("flush_full_after", 128'({out_count, out_dec_valid}), 128'(0));

        // Flush with room left: the same-cycle push must be dropped.
        in_dec_ready = 1'b0;
        send(3, 32'h4000);
        send(4, 32'h4004);
        chk("partial_before_flush", 128'({out_count, out_inst_ready}), 128'({2'd1, 1'b1}));
        in_flush = 1'b1;
        in_inst_valid = 1'b1;
        in_inst = vt[5].inst;
        in_pc = 32'h4008;
        cycles(1);
        in_flush = 1'b0;
        in_inst_valid = 1'b0;
        q.delete();
        chk("flush_partial", 128'({out_count, out_dec_valid}), 128'(0));
        in_dec_ready = 1'b1;
        cycles(4);
        chk("flush_partial_after", 128'({out_count, out_dec_valid}), 128'(0));

        // Asynchronous reset mid-stream.
        in_dec_ready = 1'b0;
        send(5, 32'h5000);
        send(6, 32'h5004);
        @(posedge in_clk);
        #3;
        in_rst = 1'b0;
        #1;
        q.delete();
        chk("async_reset_outputs", 128'({out_dec_valid, out_op, out_illegal, out_rs1, out_rs2, out_rd, out_imm, out_pc}), 128'(0));
        chk("async_reset_count_ready", 128'({out_count, out_inst_ready}), 128'({2'd0, 1'b1}));
        @(posedge in_clk);
        #1;
        in_rst = 1'b1;
        in_dec_ready = 1'b1;
        cycles(1);
        send(0, 32'h200);
        drain();
        chk("post_reset_idle", 128'({out_count, out_dec_valid}), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
